// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the multiply sequencer: ALU opcodes, flag bit positions and FSM states.
// Signed operation is selected by defining ALU_MUL_SIGNED_EN.
package alu_mul_sequencer_pkg;

   localparam logic [3:0] AluAdd = 4'b0000;
   localparam logic [3:0] AluSub = 4'b0001;
   localparam logic [3:0] AluXor = 4'b0100;
   localparam logic [3:0] AluNon = 4'b1111;

   localparam int unsigned FlagS = 3;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

   typedef enum logic [2:0] {
      StIdle,
      StPrepA,
      StPrepB,
      StMul,
      StNegLo,
      StNegHi,
      StNegHi2,
      StFin
   } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add 16x16->32 multiplier that borrows the shared ALU while busy; CPU requests pass
// through when idle. Define ALU_MUL_SIGNED_EN for two's-complement operands and product.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [WIDTH-1:0]   cpu_a_i,
   input  logic [WIDTH-1:0]   cpu_b_i,
   input  logic [3:0]         cpu_sel_i,
   output logic               cpu_stall_o,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   op_a_i,
   input  logic [WIDTH-1:0]   op_b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o,
   output logic [WIDTH-1:0]   alu_a_o,
   output logic [WIDTH-1:0]   alu_b_o,
   output logic [3:0]         alu_sel_o,
   input  logic [WIDTH-1:0]   alu_res_i,
   input  logic [3:0]         alu_flags_i
);

   seq_state_e         state_q;
   logic [WIDTH-1:0]   m_q, q_q, p_hi_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q, done_q;
   logic [2*WIDTH-1:0] prod_q;
`ifdef ALU_MUL_SIGNED_EN
   logic               neg_q, lz_q;
`endif

   logic               carry;
   logic [2*WIDTH-1:0] step_d;
   logic               unused_flags;

   assign carry        = alu_flags_i[FlagC];
   assign unused_flags = ^{alu_flags_i[FlagS], alu_flags_i[FlagZ], alu_flags_i[FlagV]};
   // One shift-add step: {carry, sum, multiplier} shifted right by one.
   assign step_d       = {carry, alu_res_i, q_q[WIDTH-1:1]};

   always_comb begin
      alu_a_o   = '0;
      alu_b_o   = '0;
      alu_sel_o = AluNon;
      case (state_q)
         StIdle: begin
            alu_a_o   = cpu_a_i;
            alu_b_o   = cpu_b_i;
            alu_sel_o = cpu_sel_i;
         end
         StMul: begin
            alu_a_o   = p_hi_q;
            alu_b_o   = q_q[0] ? m_q : '0;
            alu_sel_o = AluAdd;
         end
`ifdef ALU_MUL_SIGNED_EN
         StPrepA: begin
            alu_b_o   = m_q;
            alu_sel_o = AluSub;
         end
         StPrepB, StNegLo: begin
            alu_b_o   = q_q;
            alu_sel_o = AluSub;
         end
         StNegHi: begin
            alu_a_o   = p_hi_q;
            alu_b_o   = '1;
            alu_sel_o = AluXor;
         end
         StNegHi2: begin
            alu_a_o   = p_hi_q;
            alu_b_o   = {{(WIDTH-1){1'b0}}, lz_q};
            alu_sel_o = AluAdd;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         m_q     <= '0;
         q_q     <= '0;
         p_hi_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
`ifdef ALU_MUL_SIGNED_EN
         neg_q   <= 1'b0;
         lz_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  m_q    <= op_a_i;
                  q_q    <= op_b_i;
                  p_hi_q <= '0;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
`ifdef ALU_MUL_SIGNED_EN
                  neg_q   <= op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
                  state_q <= StPrepA;
`else
                  state_q <= StMul;
`endif
               end
            end
`ifdef ALU_MUL_SIGNED_EN
            StPrepA: begin
               if (m_q[WIDTH-1]) m_q <= alu_res_i;
               state_q <= StPrepB;
            end
            StPrepB: begin
               if (q_q[WIDTH-1]) q_q <= alu_res_i;
               state_q <= StMul;
            end
`endif
            StMul: begin
               {p_hi_q, q_q} <= step_d;
               cnt_q         <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef ALU_MUL_SIGNED_EN
                  state_q <= StNegLo;
`else
                  // Product is loaded here so it is already valid in the DONE cycle.
                  prod_q  <= step_d;
                  done_q  <= 1'b1;
                  state_q <= StFin;
`endif
               end
            end
`ifdef ALU_MUL_SIGNED_EN
            StNegLo: begin
               lz_q <= (q_q == '0);
               if (neg_q) q_q <= alu_res_i;
               state_q <= StNegHi;
            end
            StNegHi: begin
               if (neg_q) p_hi_q <= alu_res_i;
               state_q <= StNegHi2;
            end
            StNegHi2: begin
               prod_q  <= {(neg_q ? alu_res_i : p_hi_q), q_q};
               done_q  <= 1'b1;
               state_q <= StFin;
            end
`endif
            StFin: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign cpu_stall_o = busy_q;
   assign done_o      = done_q;
   assign prod_o      = prod_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU and a product scoreboard.
// Honours ALU_MUL_SIGNED_EN for expected products and latency.
module tb_alu_mul_sequencer;

`ifdef ALU_MUL_SIGNED_EN
   localparam int Lat = 22;
`else
   localparam int Lat = 17;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cpu_a, cpu_b, op_a, op_b, alu_a, alu_b, alu_res;
   logic [3:0]  cpu_sel, alu_sel, alu_flags;
   logic        cpu_stall, start, busy, done;
   logic [31:0] prod;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   alu_mul_sequencer dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cpu_a_i     (cpu_a),
      .cpu_b_i     (cpu_b),
      .cpu_sel_i   (cpu_sel),
      .cpu_stall_o (cpu_stall),
      .start_i     (start),
      .op_a_i      (op_a),
      .op_b_i      (op_b),
      .busy_o      (busy),
      .done_o      (done),
      .prod_o      (prod),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_sel_o   (alu_sel),
      .alu_res_i   (alu_res),
      .alu_flags_i (alu_flags)
   );

   // Behavioural 16-bit ALU; carry is the 17th bit of the add/sub.
   logic [16:0] alu_wide;
   always_comb begin
      alu_wide = '0;
      case (alu_sel)
         4'b0000: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
         4'b0001: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
         4'b0100: alu_wide = {1'b0, alu_a ^ alu_b};
         default: alu_wide = '0;
      endcase
      alu_res   = alu_wide[15:0];
      alu_flags = {alu_wide[15], (alu_wide[15:0] == 16'h0), alu_wide[16], 1'b0};
   end

   function automatic logic [31:0] exp_prod(input logic [15:0] a, input logic [15:0] b);
`ifdef ALU_MUL_SIGNED_EN
      logic signed [31:0] sa, sb;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return sa * sb;
`else
      return {16'h0, a} * {16'h0, b};
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit poke);
      bit seen;
      logic [31:0] exp;
      exp_q.push_back(exp_prod(a, b));
      @(negedge clk);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      @(negedge clk);
      start = 1'b0;
      op_a  = ~a;
      op_b  = ~b;
      seen  = 1'b0;
      for (int k = 1; k <= Lat + 3 && !seen; k++) begin
         if (poke && k == 4) start = 1'b1;
         if (poke && k == 5) start = 1'b0;
         chk("stall", {31'h0, cpu_stall}, 32'h1);
         chk("busy", {31'h0, busy}, 32'h1);
         if (done) begin
            seen = 1'b1;
            chk("latency", 32'(k), 32'(Lat));
            exp = exp_q.pop_front();
            chk("prod", prod, exp);
         end else begin
            @(negedge clk);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $error("FAIL done_timeout observed=none expected=%0d", Lat);
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      op_a    = '0;
      op_b    = '0;
      cpu_a   = 16'h1111;
      cpu_b   = 16'h2222;
      cpu_sel = 4'b0100;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
      chk("rst_prod", prod, 32'h0);
      chk("rst_sel", {28'h0, alu_sel}, 32'h4);
      rst_n = 1'b1;

      // Pass-through while idle
      @(negedge clk);
      cpu_sel = 4'b0000;
      cpu_a   = 16'd2;
      cpu_b   = 16'd3;
      #1;
      chk("pt_a", {16'h0, alu_a}, 32'd2);
      chk("pt_b", {16'h0, alu_b}, 32'd3);
      chk("pt_sel", {28'h0, alu_sel}, 32'h0);
      chk("pt_res", {16'h0, alu_res}, 32'd5);

      run_mul(16'h0003, 16'h0005, 1'b0);
      run_mul(16'hFFFF, 16'hFFFF, 1'b0);   // back-to-back with previous
      run_mul(16'h0000, 16'h1234, 1'b0);
      run_mul(16'h1234, 16'h0000, 1'b0);
      run_mul(16'h1234, 16'h5678, 1'b1);   // START re-asserted while busy
      run_mul(16'(($urandom) & 16'h7FFF), 16'(($urandom) & 16'h7FFF), 1'b0);
      run_mul(16'hA5A5, 16'h0101, 1'b0);
`ifdef ALU_MUL_SIGNED_EN
      run_mul(16'hFFFE, 16'h0003, 1'b0);
      run_mul(16'h8000, 16'h8000, 1'b0);
      run_mul(16'h7FFF, 16'h8000, 1'b0);
`endif
      @(negedge clk);
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("idle_done", {31'h0, done}, 32'h0);
      chk("hold_prod", prod, exp_prod(16'hA5A5, 16'h0101) `ifdef ALU_MUL_SIGNED_EN * 0 +
         exp_prod(16'h7FFF, 16'h8000) `endif);
      cpu_sel = 4'b0001;
      #1;
      chk("idle_sel", {28'h0, alu_sel}, 32'h1);

      // Abort with reset partway through the multiply
      @(negedge clk);
      start = 1'b1;
      op_a  = 16'h0003;
      op_b  = 16'h0005;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("abort_busy_pre", {31'h0, busy}, 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      chk("abort_prod", prod, 32'h0);
      chk("abort_sel", {28'h0, alu_sel}, {28'h0, cpu_sel});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("abort_no_done", {31'h0, done}, 32'h0);
      end
      run_mul(16'h0007, 16'h0009, 1'b0);

      chk("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
